// File: rtl/wb_pkg.sv
// Shared constants, state type and helpers for the Wishbone B3 initiator.
package wb_pkg;

    // Cycle type identifiers driven on cti_o
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Only linear bursts are issued
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RETRY = 2'd2,
        DONE  = 2'd3
    } wbm_state_t;

    // Cycle type for a beat: classic for single transfers, end-of-burst
    // on the final beat of a burst, incrementing otherwise.
    function automatic logic [2:0] beat_cti(input logic is_burst, input logic is_last);
        logic [2:0] cti;
        if (!is_burst) begin
            cti = CTI_CLASSIC;
        end else if (is_last) begin
            cti = CTI_EOB;
        end else begin
            cti = CTI_INCR;
        end
        return cti;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// No-response watchdog: counts consecutive enabled cycles and flags expiry
// on the TIMEOUT-th one. A TIMEOUT of 0 removes the counter entirely.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Count only unbroken runs of enabled cycles; a clear or an idle cycle restarts
            always_comb begin
                cnt_d = cnt_q;
                if (clr_i || !en_i) begin
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end

            // Counter register
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= {CW{1'b0}};
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Expire in the cycle that would be the TIMEOUT-th silent one
            assign expire_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wb_master.sv
// Wishbone B3 initiator: takes one command at a time, issues a single or
// linear incrementing burst, handles err/rty/ack with bounded retry and a
// no-response watchdog, streams read data and reports completion status.
module wb_master
    import wb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LENW      = 8,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic            clk,
    input  logic            rst,
    // command port
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic [LENW-1:0] cmd_len,
    // write data stream
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    // read data stream and status
    output logic            rd_valid,
    output logic [DW-1:0]   rd_dat,
    output logic            done,
    output logic            done_err,
    // Wishbone initiator side
    output logic [AW-1:0]   adr_o,
    output logic            stb_o,
    output logic            cyc_o,
    output logic [DW/8-1:0] sel_o,
    output logic            we_o,
    output logic [2:0]      cti_o,
    output logic [1:0]      bte_o,
    output logic [DW-1:0]   dat_o,
    input  logic [DW-1:0]   dat_i,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            rty_i
);

    localparam int SW = DW / 8;
    localparam int RW = $clog2(MAX_RETRY + 2);

    wbm_state_t      state_q,      state_d;
    logic [AW-1:0]   adr_q,        adr_d;
    logic [SW-1:0]   sel_q,        sel_d;
    logic            we_q,         we_d;
    logic [LENW-1:0] len_q,        len_d;
    logic [LENW-1:0] beat_q,       beat_d;
    logic [RW-1:0]   retry_q,      retry_d;
    logic            cyc_q,        cyc_d;
    logic            stb_q,        stb_d;
    logic [2:0]      cti_q,        cti_d;
    logic [DW-1:0]   dat_q,        dat_d;
    logic [DW-1:0]   rd_dat_q,     rd_dat_d;
    logic            rd_valid_q,   rd_valid_d;
    logic            wdat_ready_q, wdat_ready_d;
    logic            done_q,       done_d;
    logic            done_err_q,   done_err_d;

    logic            accept_s;
    logic            resp_live_s;
    logic            resp_any_s;
    logic            is_err_s;
    logic            is_rty_s;
    logic            is_ack_s;
    logic            last_beat_s;
    logic            wd_expire_s;

    assign cmd_ready   = rst && (state_q == IDLE);
    assign accept_s    = cmd_valid && cmd_ready;

    // Responses only count while a strobe is actually on the bus
    assign resp_live_s = (state_q == BUS) && stb_q;
    assign resp_any_s  = resp_live_s && (ack_i || err_i || rty_i);
    assign is_err_s    = resp_live_s && err_i;
    assign is_rty_s    = resp_live_s && !err_i && rty_i;
    assign is_ack_s    = resp_live_s && !err_i && !rty_i && ack_i;
    assign last_beat_s = (beat_q == len_q);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (resp_any_s),
        .en_i     (resp_live_s),
        .expire_o (wd_expire_s)
    );

    // Next-state and next-output logic for the transfer FSM
    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        we_d         = we_q;
        len_d        = len_q;
        beat_d       = beat_q;
        retry_d      = retry_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        cti_d        = cti_q;
        dat_d        = dat_q;
        rd_dat_d     = rd_dat_q;
        rd_valid_d   = 1'b0;
        wdat_ready_d = 1'b0;
        done_d       = 1'b0;
        done_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = BUS;
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    sel_d   = cmd_sel;
                    len_d   = cmd_len;
                    beat_d  = {LENW{1'b0}};
                    retry_d = {RW{1'b0}};
                    cyc_d   = 1'b1;
                    cti_d   = beat_cti(cmd_len != {LENW{1'b0}}, cmd_len == {LENW{1'b0}});
                    if (cmd_we) begin
                        // A write strobe waits until its data word is present
                        stb_d = wdat_valid;
                        dat_d = wdat;
                    end else begin
                        stb_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            BUS: begin
                if (!stb_q) begin
                    // Write wait state; the word on wdat is stale while its
                    // consumption pulse is still out, so it is skipped then.
                    if (wdat_valid && !wdat_ready_q) begin
                        stb_d = 1'b1;
                        dat_d = wdat;
                    end else begin
                        stb_d = 1'b0;
                    end
                end else if (is_err_s) begin
                    state_d    = DONE;
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                end else if (is_rty_s) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (retry_q >= RW'(MAX_RETRY)) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end else begin
                        state_d = RETRY;
                        retry_d = retry_q + {{(RW-1){1'b0}}, 1'b1};
                    end
                end else if (is_ack_s) begin
                    if (we_q) begin
                        wdat_ready_d = 1'b1;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_dat_d   = dat_i;
                    end
                    if (last_beat_s) begin
                        state_d = DONE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        adr_d   = adr_q + AW'(SW);
                        beat_d  = beat_q + {{(LENW-1){1'b0}}, 1'b1};
                        retry_d = {RW{1'b0}};
                        cti_d   = beat_cti(1'b1, (beat_q + {{(LENW-1){1'b0}}, 1'b1}) == len_q);
                        // Reads continue back-to-back; writes refetch their next word
                        stb_d   = !we_q;
                    end
                end else if (wd_expire_s) begin
                    state_d    = DONE;
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                end else begin
                    stb_d = 1'b1;
                end
            end

            RETRY: begin
                // Same beat and address; write data is still held in dat_q
                state_d = BUS;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
            end

            DONE: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State, command context and registered bus/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            adr_q        <= {AW{1'b0}};
            sel_q        <= {SW{1'b0}};
            we_q         <= 1'b0;
            len_q        <= {LENW{1'b0}};
            beat_q       <= {LENW{1'b0}};
            retry_q      <= {RW{1'b0}};
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            cti_q        <= CTI_CLASSIC;
            dat_q        <= {DW{1'b0}};
            rd_dat_q     <= {DW{1'b0}};
            rd_valid_q   <= 1'b0;
            wdat_ready_q <= 1'b0;
            done_q       <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            retry_q      <= retry_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            cti_q        <= cti_d;
            dat_q        <= dat_d;
            rd_dat_q     <= rd_dat_d;
            rd_valid_q   <= rd_valid_d;
            wdat_ready_q <= wdat_ready_d;
            done_q       <= done_d;
            done_err_q   <= done_err_d;
        end
    end

    assign adr_o      = adr_q;
    assign stb_o      = stb_q;
    assign cyc_o      = cyc_q;
    assign sel_o      = sel_q;
    assign we_o       = we_q;
    assign cti_o      = cti_q;
    assign bte_o      = BTE_LINEAR;
    assign dat_o      = dat_q;
    assign rd_valid   = rd_valid_q;
    assign rd_dat     = rd_dat_q;
    assign wdat_ready = wdat_ready_q;
    assign done       = done_q;
    assign done_err   = done_err_q;

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: directed scenarios followed by random commands, with a
// scripted slave and a transaction-level reference of the expected outcome.
module tb_wb_master;

    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 64;

    localparam int K_ACK = 0;
    localparam int K_ERR = 1;
    localparam int K_RTY = 2;
    localparam int K_SIL = 3;
    localparam int K_ALL = 4;
    localparam int K_RA  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'h0;
    logic [3:0]  cmd_sel = 4'h0;
    logic [7:0]  cmd_len = 8'h0;
    logic        wdat_valid = 1'b0;
    logic        wdat_ready;
    logic [31:0] wdat = 32'h0;
    logic        rd_valid;
    logic [31:0] rd_dat;
    logic        done;
    logic        done_err;
    logic [31:0] adr_o;
    logic        stb_o;
    logic        cyc_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic        rty_i = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Scenario description shared by the directed and random steps
    int          plan_kind [64];
    int          plan_wait [64];
    int          gap_before [32];
    logic [31:0] wbeat [32];
    logic [31:0] rbeat [32];
    int          exp_stb;
    logic        spur_en;
    int          last_rd_idx;
    int          last_done_idx;

    wb_master #(
        .AW(32), .DW(32), .LENW(8), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rd_valid(rd_valid), .rd_dat(rd_dat), .done(done), .done_err(done_err),
        .adr_o(adr_o), .stb_o(stb_o), .cyc_o(cyc_o), .sel_o(sel_o), .we_o(we_o),
        .cti_o(cti_o), .bte_o(bte_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 64; i++) begin
            plan_kind[i] = K_ACK;
            plan_wait[i] = 0;
        end
        for (int i = 0; i < 32; i++) begin
            gap_before[i] = 0;
            wbeat[i] = $urandom();
            rbeat[i] = $urandom();
        end
        exp_stb = -1;
        spur_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_adr"}, 64'(adr_o), 64'h0);
        check({tag, "_cyc_stb"}, 64'({cyc_o, stb_o}), 64'h0);
        check({tag, "_sel_we"}, 64'({sel_o, we_o}), 64'h0);
        check({tag, "_cti_bte"}, 64'({cti_o, bte_o}), 64'h0);
        check({tag, "_dat"}, 64'(dat_o), 64'h0);
        check({tag, "_rd"}, 64'({rd_valid, rd_dat}), 64'h0);
        check({tag, "_status"}, 64'({done, done_err, wdat_ready, cmd_ready}), 64'h0);
    endtask

    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [7:0] len);
        int          b, r, att, e_n, e_drop, e_wr;
        logic        e_err;
        logic [31:0] e_adr [64];
        logic [2:0]  e_cti [64];
        logic [31:0] e_dat [64];
        logic [31:0] e_rdq [$];
        logic [31:0] o_adr [64];
        logic [2:0]  o_cti [64];
        logic [31:0] o_dat [64];
        logic [6:0]  o_misc [64];
        logic [31:0] o_rdq [$];
        int          o_n, drops, wr_cnt, stb_cyc, att_i, wait_c, w_idx, gap_cnt, idx, k;
        logic        finished, got_err;

        // Reference: walk the response script beat by beat
        b = 0; r = 0; att = 0; e_n = 0; e_drop = 0; e_wr = 0; e_err = 1'b0;
        while (1'b1) begin
            if (att >= 64 || plan_kind[att] == K_SIL) begin
                e_err = 1'b1;
                break;
            end
            k = plan_kind[att];
            e_adr[e_n] = adr + 32'(4 * b);
            e_cti[e_n] = (len == 8'd0) ? 3'b000 : ((b == int'(len)) ? 3'b111 : 3'b010);
            e_dat[e_n] = wbeat[b];
            e_n++;
            att++;
            if (k == K_ERR || k == K_ALL) begin
                e_err = 1'b1;
                break;
            end
            if (k == K_RTY || k == K_RA) begin
                r++;
                if (r > MAX_RETRY) begin
                    e_err = 1'b1;
                    break;
                end
                e_drop++;
                continue;
            end
            if (we) e_wr++;
            else e_rdq.push_back(rbeat[b]);
            if (b == int'(len)) break;
            b++;
            r = 0;
        end

        // Present the command
        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'h1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_len = len;
        w_idx = 0; gap_cnt = gap_before[0]; wdat = wbeat[0];
        wdat_valid = we && (gap_cnt == 0);
        @(posedge clk);
        o_n = 0; drops = 0; wr_cnt = 0; stb_cyc = 0; att_i = 0; wait_c = 0;
        idx = 0; finished = 1'b0; got_err = 1'b0;
        last_rd_idx = 0; last_done_idx = 0;

        while (!finished && idx < 400) begin
            @(negedge clk);
            idx++;
            cmd_valid = 1'b0;
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
            if (done) begin
                finished = 1'b1;
                got_err = done_err;
                last_done_idx = idx;
            end
            if (rd_valid) begin
                o_rdq.push_back(rd_dat);
                if (last_rd_idx == 0) last_rd_idx = idx;
            end
            if (!cyc_o && !done) drops++;
            // Write-data source: advance after each consumption pulse
            if (wdat_ready) begin
                wr_cnt++;
                w_idx = (w_idx < 31) ? w_idx + 1 : 31;
                gap_cnt = gap_before[w_idx];
                wdat = wbeat[w_idx];
                wdat_valid = we && (w_idx <= int'(len)) && (gap_cnt == 0);
            end else if (we && !wdat_valid && gap_cnt > 0 && w_idx <= int'(len)) begin
                gap_cnt--;
                if (gap_cnt == 0) wdat_valid = 1'b1;
            end
            // Scripted slave
            if (!finished && cyc_o && stb_o) begin
                stb_cyc++;
                k = (att_i < 64) ? plan_kind[att_i] : K_SIL;
                if (k != K_SIL && wait_c >= plan_wait[att_i]) begin
                    if (o_n < 64) begin
                        o_adr[o_n] = adr_o; o_cti[o_n] = cti_o; o_dat[o_n] = dat_o;
                        o_misc[o_n] = {bte_o, we_o, sel_o};
                        o_n++;
                    end
                    ack_i = (k == K_ACK || k == K_ALL || k == K_RA);
                    err_i = (k == K_ERR || k == K_ALL);
                    rty_i = (k == K_RTY || k == K_ALL || k == K_RA);
                    dat_i = rbeat[((adr_o - adr) >> 2) & 32'd31];
                    att_i++;
                    wait_c = 0;
                end else begin
                    wait_c++;
                end
            end else if (!finished && cyc_o && spur_en) begin
                ack_i = 1'b1; err_i = 1'b1; rty_i = 1'b1;
            end
        end
        wdat_valid = 1'b0;

        check("cmd_completes", 64'(finished), 64'h1);
        check("attempts", 64'(o_n), 64'(e_n));
        for (int i = 0; i < o_n && i < e_n; i++) begin
            check("beat_adr", 64'(o_adr[i]), 64'(e_adr[i]));
            check("beat_cti", 64'(o_cti[i]), 64'(e_cti[i]));
            check("beat_bte_we_sel", 64'(o_misc[i]), 64'({2'b00, we, sel}));
            if (we) check("beat_wdat", 64'(o_dat[i]), 64'(e_dat[i]));
        end
        check("rd_count", 64'(o_rdq.size()), 64'(e_rdq.size()));
        for (int i = 0; i < o_rdq.size() && i < e_rdq.size(); i++) begin
            check("rd_data", 64'(o_rdq[i]), 64'(e_rdq[i]));
        end
        check("done_err", 64'(got_err), 64'(e_err));
        check("retry_gaps", 64'(drops), 64'(e_drop));
        check("wdat_ready_count", 64'(wr_cnt), 64'(e_wr));
        if (exp_stb >= 0) check("stb_cycles", 64'(stb_cyc), 64'(exp_stb));
        @(negedge clk);
        check("done_one_cycle", 64'({done, cyc_o, stb_o}), 64'h0);
        check("cmd_ready_after", 64'(cmd_ready), 64'h1);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Single write, two wait states
        clear_plan();
        wbeat[0] = 32'hDEADBEEF; plan_wait[0] = 2; exp_stb = 3;
        run_cmd(1'b1, 32'h10, 4'hF, 8'd0);

        // Single zero-wait read: latency from accept
        clear_plan();
        exp_stb = 1;
        run_cmd(1'b0, 32'h40, 4'h3, 8'd0);
        check("lat_rd_valid", 64'(last_rd_idx), 64'd2);
        check("lat_done", 64'(last_done_idx), 64'd2);

        // Four-beat zero-wait read burst
        clear_plan();
        for (int i = 0; i < 4; i++) rbeat[i] = 32'hA0 + 32'(i);
        exp_stb = 4;
        run_cmd(1'b0, 32'h100, 4'hF, 8'd3);

        // Write burst with a data gap before beat 1; stray responses in the gap
        clear_plan();
        gap_before[1] = 2; spur_en = 1'b1; exp_stb = 3;
        run_cmd(1'b1, 32'h200, 4'hC, 8'd2);

        // Two retries then ack
        clear_plan();
        plan_kind[0] = K_RTY; plan_kind[1] = K_RTY; exp_stb = 3;
        run_cmd(1'b0, 32'h300, 4'hF, 8'd0);

        // Retry budget exhausted
        clear_plan();
        for (int i = 0; i < 4; i++) plan_kind[i] = K_RTY;
        run_cmd(1'b1, 32'h304, 4'hF, 8'd0);

        // Silent slave hits the watchdog
        clear_plan();
        plan_kind[0] = K_SIL; exp_stb = TIMEOUT;
        run_cmd(1'b0, 32'h400, 4'hF, 8'd0);
        check("timeout_done_idx", 64'(last_done_idx), 64'(TIMEOUT + 1));

        // Error on the second beat of a four-beat read
        clear_plan();
        plan_kind[1] = K_ERR;
        run_cmd(1'b0, 32'h500, 4'hF, 8'd3);
        check("err_adr_frozen", 64'(adr_o), 64'h504);

        // Simultaneous responses: err wins, rty beats ack
        clear_plan();
        plan_kind[0] = K_ALL;
        run_cmd(1'b0, 32'h600, 4'hF, 8'd1);
        clear_plan();
        plan_kind[0] = K_RA;
        run_cmd(1'b1, 32'h604, 4'h5, 8'd1);

        // Address wrap past the top of the space
        clear_plan();
        run_cmd(1'b0, 32'hFFFF_FFF8, 4'hF, 8'd2);

        // Random commands
        for (int n = 0; n < 24; n++) begin
            clear_plan();
            for (int i = 0; i < 64; i++) begin
                k_pick(i);
            end
            for (int i = 0; i < 32; i++) gap_before[i] = $urandom_range(0, 2);
            spur_en = 1'($urandom_range(0, 1));
            run_cmd(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC,
                    4'($urandom_range(0, 15)), 8'($urandom_range(0, 7)));
        end

        // Reset in the middle of a burst
        clear_plan();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h700; cmd_sel = 4'hF; cmd_len = 8'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midburst_active", 64'({cyc_o, stb_o}), 64'h3);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_idle_outputs("midburst_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_in_reset", 64'({done, cyc_o}), 64'h0);
        end
        rst = 1'b1;
        clear_plan();
        run_cmd(1'b0, 32'h800, 4'hF, 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Random response choice for one slot of the script
    task automatic k_pick(input int i);
        int r;
        r = $urandom_range(0, 99);
        if (r < 8) plan_kind[i] = K_RTY;
        else if (r < 12) plan_kind[i] = K_ERR;
        else if (r < 14) plan_kind[i] = K_RA;
        else plan_kind[i] = K_ACK;
        plan_wait[i] = $urandom_range(0, 2);
    endtask

endmodule
